// File: rtl/seq_mul.sv
// Multi-cycle unsigned shift-add multiplier with a start/busy/done handshake.
// One add per RUN cycle; the full 2*DATAWIDTH product is ready DATAWIDTH+1 cycles after start.
module seq_mul #(
    parameter int DATAWIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic [DATAWIDTH-1:0]     a,
    input  logic [DATAWIDTH-1:0]     b,
    output logic                     busy,
    output logic                     done,
    output logic [2*DATAWIDTH-1:0]   prod
);

    localparam int PW = 2 * DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       acc_q;
    logic [PW-1:0]       mcand_q;
    logic [DATAWIDTH-1:0] mplier_q;
    logic [CW-1:0]       count_q;
    logic [PW-1:0]       prod_q;
    logic                busy_q;
    logic                done_q;

    logic [PW-1:0]       acc_d;
    logic                last_d;

    // The accumulator never exceeds (2^W-1)^2, so the PW-bit add cannot overflow.
    always_comb begin
        acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        last_d = (count_q == CW'(DATAWIDTH - 1));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // Operands are only captured with start, so X on a/b while idle never lands in state.
                    if (start) begin
                        mcand_q  <= {{DATAWIDTH{1'b0}}, a};
                        mplier_q <= b;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CW'(1);
                    if (last_d) begin
                        prod_q  <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: W=8 handshake/latency/reset scenarios plus W=2 and W=16 builds.
module tb_seq_mul;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start2 = 1'b0;
    logic [1:0]  a2 = '0, b2 = '0;
    logic        busy2, done2;
    logic [3:0]  prod2;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    int checks = 0;
    int errors = 0;

    seq_mul #(.DATAWIDTH(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .prod(prod8)
    );
    seq_mul #(.DATAWIDTH(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .prod(prod2)
    );
    seq_mul #(.DATAWIDTH(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .prod(prod16)
    );

    // Runs one W=8 operation; lat counts negedges from driving start until done is seen.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input bit noise,
                           output int lat, output logic [15:0] p, output bit held,
                           output logic busy_first, output logic busy_after, output logic done_after);
        logic [15:0] p0;
        @(negedge Clk);
        a8 = ta; b8 = tb_; start8 = 1'b1;
        p0 = prod8;
        @(negedge Clk);
        lat = 1;
        busy_first = busy8;
        held = 1'b1;
        start8 = noise;
        a8 = noise ? 8'd3 : 8'hxx;
        b8 = noise ? 8'd3 : 8'hxx;
        while (done8 !== 1'b1 && lat < 40) begin
            if (prod8 !== p0) held = 1'b0;
            @(negedge Clk);
            lat++;
        end
        p = prod8;
        start8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge Clk);
        busy_after = busy8;
        done_after = done8;
    endtask

    task automatic run_op2(input logic [1:0] ta, input logic [1:0] tb_, output int lat, output logic [3:0] p);
        @(negedge Clk);
        a2 = ta; b2 = tb_; start2 = 1'b1;
        @(negedge Clk);
        start2 = 1'b0;
        lat = 1;
        while (done2 !== 1'b1 && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        p = prod2;
        @(negedge Clk);
    endtask

    task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb_, output int lat, output logic [31:0] p);
        @(negedge Clk);
        a16 = ta; b16 = tb_; start16 = 1'b1;
        @(negedge Clk);
        start16 = 1'b0;
        lat = 1;
        while (done16 !== 1'b1 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        p = prod16;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b prod=%h required 0/0/0000", busy8, done8, prod8);
        end
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0/0", busy8, done8);
        end
        $display("reset: busy=%b done=%b prod=%h", busy8, done8, prod8);
    endtask

    task automatic test_max_operands();
        int lat; logic [15:0] p; bit held; logic bf, ba, da;
        run_op8(8'd255, 8'd255, 1'b0, lat, p, held, bf, ba, da);
        $display("op 255*255: lat=%0d prod=%h", lat, p);
        checks++;
        if (bf !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b required 1", bf); end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL latency_255 got %0d required 9", lat); end
        checks++;
        if (p !== 16'hFE01) begin errors++; $display("FAIL prod_255 got %h required fe01", p); end
        checks++;
        if (ba !== 1'b0 || da !== 1'b0) begin
            errors++; $display("FAIL after_done busy=%b done=%b required 0/0", ba, da);
        end
    endtask

    task automatic test_zero_operands();
        int lat; logic [15:0] p; bit held; logic bf, ba, da;
        run_op8(8'd0, 8'd200, 1'b0, lat, p, held, bf, ba, da);
        $display("op 0*200: lat=%0d prod=%h held=%0d", lat, p, held);
        checks++;
        if (!held) begin errors++; $display("FAIL prod_hold prod changed before done, required fe01 held"); end
        checks++;
        if (lat !== 9 || p !== 16'h0) begin
            errors++; $display("FAIL zero_a lat=%0d prod=%h required 9/0000", lat, p);
        end
        run_op8(8'd13, 8'd0, 1'b0, lat, p, held, bf, ba, da);
        $display("op 13*0: lat=%0d prod=%h", lat, p);
        checks++;
        if (lat !== 9 || p !== 16'h0) begin
            errors++; $display("FAIL zero_b lat=%0d prod=%h required 9/0000", lat, p);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] p; bit held; logic bf, ba, da;
        run_op8(8'd12, 8'd11, 1'b1, lat, p, held, bf, ba, da);
        $display("op 12*11 with start noise: lat=%0d prod=%0d", lat, p);
        checks++;
        if (lat !== 9 || p !== 16'd132) begin
            errors++; $display("FAIL ignore_start lat=%0d prod=%0d required 9/132", lat, p);
        end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL start_not_queued busy=%b required 0", ba); end
        run_op8(8'd3, 8'd3, 1'b0, lat, p, held, bf, ba, da);
        $display("op 3*3: lat=%0d prod=%0d", lat, p);
        checks++;
        if (lat !== 9 || p !== 16'd9) begin
            errors++; $display("FAIL next_op lat=%0d prod=%0d required 9/9", lat, p);
        end
    endtask

    task automatic test_async_reset();
        int lat; int pulses; logic [15:0] p; bit held; logic bf, ba, da;
        @(negedge Clk);
        a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(negedge Clk);
        start8 = 1'b0;
        repeat (4) @(negedge Clk);
        #1 Rst = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b prod=%h required 0/0/0000", busy8, done8, prod8);
        end
        @(negedge Clk);
        Rst = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge Clk);
            if (done8 === 1'b1) pulses++;
        end
        $display("abort 100*100: done pulses after release=%0d", pulses);
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL aborted_done got %0d pulses required 0", pulses); end
        run_op8(8'd7, 8'd6, 1'b0, lat, p, held, bf, ba, da);
        $display("op 7*6: lat=%0d prod=%0d", lat, p);
        checks++;
        if (lat !== 9 || p !== 16'd42) begin
            errors++; $display("FAIL after_abort lat=%0d prod=%0d required 9/42", lat, p);
        end
    endtask

    // start held high: accepts at iterations 0,10,20,...; done seen 9 iterations later.
    task automatic test_start_held();
        logic [15:0] exp_p [0:63];
        logic exp_done;
        int dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            exp_done = (i >= 9) && (((i - 9) % 10) == 0);
            checks++;
            if (done8 !== exp_done) begin
                errors++; $display("FAIL held_done iter=%0d done=%b required %b", i, done8, exp_done);
            end
            if (exp_done) begin
                dones++;
                $display("held op iter=%0d prod=%0d expected=%0d", i - 9, prod8, exp_p[i-9]);
                checks++;
                if (prod8 !== exp_p[i-9]) begin
                    errors++; $display("FAIL held_prod iter=%0d got %0d required %0d", i, prod8, exp_p[i-9]);
                end
            end
            a8 = 8'(i + 1);
            b8 = 8'(200 - i);
            exp_p[i] = 16'(i + 1) * 16'(200 - i);
            start8 = 1'b1;
        end
        @(negedge Clk);
        start8 = 1'b0;
        repeat (12) @(negedge Clk);
        checks++;
        if (dones !== 6) begin errors++; $display("FAIL held_count got %0d required 6", dones); end
    endtask

    task automatic test_width2();
        int lat; logic [3:0] p;
        run_op2(2'd3, 2'd3, lat, p);
        $display("w2 op 3*3: lat=%0d prod=%h", lat, p);
        checks++;
        if (lat !== 3 || p !== 4'h9) begin
            errors++; $display("FAIL w2_max lat=%0d prod=%h required 3/9", lat, p);
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ia, ib;
            ia = 4'(i >> 2);
            ib = 4'(i & 3);
            run_op2(ia[1:0], ib[1:0], lat, p);
            $display("w2 op %0d*%0d: prod=%0d", ia, ib, p);
            checks++;
            if (lat !== 3 || p !== 4'(ia * ib)) begin
                errors++; $display("FAIL w2_op %0d*%0d lat=%0d prod=%0d required 3/%0d", ia, ib, lat, p, ia * ib);
            end
        end
    endtask

    task automatic test_width16();
        int lat; logic [31:0] p; logic [31:0] ra, rb;
        for (int i = 0; i < 100; i++) begin
            ra = 32'($urandom_range(0, 65535));
            rb = 32'($urandom_range(0, 65535));
            if (i == 0) begin ra = 32'hFFFF; rb = 32'hFFFF; end
            run_op16(ra[15:0], rb[15:0], lat, p);
            $display("w16 op %0d*%0d: prod=%0d", ra, rb, p);
            checks++;
            if (lat !== 17 || p !== ra * rb) begin
                errors++; $display("FAIL w16_op %0d*%0d lat=%0d prod=%0d required 17/%0d", ra, rb, lat, p, ra * rb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_zero_operands();
        test_back_to_back();
        test_async_reset();
        test_start_held();
        test_width2();
        test_width16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
